// File: rtl/seq_alu_core_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_core_if
// Purpose  : Request/response bundle between the operand registers, the
//            sequential ALU and the result bus.
//            master : operand/request side (drives start, sel, a, b)
//            slave  : the ALU core (drives busy, done, results, ovf)
// Signals  : start, sel[1:0], a[WIDTH-1:0], b[WIDTH-1:0]   -> toward core
//            busy, done, result_hi, result_lo, ovf         <- from core
//            zero, neg (only when ALU_FLAGS_EN is defined)  <- from core
// Macro    : ALU_FLAGS_EN adds the zero/neg status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_core_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [1:0]       sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             ovf;
`ifdef ALU_FLAGS_EN
  logic             zero;
  logic             neg;

  modport master (output start, sel, a, b,
                  input  busy, done, result_hi, result_lo, ovf, zero, neg);
  modport slave  (input  start, sel, a, b,
                  output busy, done, result_hi, result_lo, ovf, zero, neg);
`else
  modport master (output start, sel, a, b,
                  input  busy, done, result_hi, result_lo, ovf);
  modport slave  (input  start, sel, a, b,
                  output busy, done, result_hi, result_lo, ovf);
`endif
endinterface
`default_nettype wire

// File: rtl/seq_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_core
// Purpose  : Parametrised sequential ALU (add, sub, signed Booth radix-2
//            multiply, unsigned non-restoring divide) with a start/busy/done
//            handshake. Datapath and one-hot controller in one block.
// Ports    : clk    - system clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - seq_alu_core_if.slave (start, sel, a, b in;
//                     busy, done, result_hi, result_lo, ovf out)
// Macro    : ALU_FLAGS_EN adds zero/neg status outputs on the interface.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu_core #(
  parameter int WIDTH = 8
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  seq_alu_core_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [6:0] {
    S_IDLE     = 7'b0000001,
    S_LOAD     = 7'b0000010,
    S_ADDSUB   = 7'b0000100,
    S_MUL_STEP = 7'b0001000,
    S_DIV_STEP = 7'b0010000,
    S_DIV_CORR = 7'b0100000,
    S_DONE     = 7'b1000000
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_busy;
  logic             w_done;

  // Captured request
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_sel;

  // Iterative datapath: A carries one extra sign bit for both algorithms
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH:0]   r_m;
  logic             r_qm1;
  logic [CNT_W-1:0] r_cnt;

  // Result registers, written only on entry to DONE
  logic [WIDTH-1:0] r_res_hi;
  logic [WIDTH-1:0] r_res_lo;
  logic             r_ovf;
`ifdef ALU_FLAGS_EN
  logic             r_zero;
  logic             r_neg;
`endif

  logic             w_last;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_addsub;
  logic             w_addsub_ovf;
  logic [WIDTH:0]   w_booth;
  logic [WIDTH:0]   w_mul_acc;
  logic [WIDTH-1:0] w_mul_q;
  logic [WIDTH:0]   w_div_sh;
  logic [WIDTH:0]   w_div_acc;
  logic [WIDTH-1:0] w_div_q;
  logic [WIDTH:0]   w_corr;

  // Exit at WIDTH-1 so the counter never needs to hold WIDTH
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_div_zero = (r_sel == 2'b11) && (r_b == '0);

  // Add/sub with two's-complement overflow detection
  assign w_addsub     = r_sel[0] ? (r_a - r_b) : (r_a + r_b);
  assign w_addsub_ovf = r_sel[0]
      ? ((r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_addsub[WIDTH-1] != r_a[WIDTH-1]))
      : ((r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_addsub[WIDTH-1] != r_a[WIDTH-1]));

  // Booth step: 10 -> subtract M, 01 -> add M, then arithmetic shift right of
  // {A,Q,q_min1}. The extra A bit keeps -2^(W-1) * -2^(W-1) from overflowing.
  always_comb begin
    w_booth = r_acc;
    if (r_q[0] && !r_qm1)
      w_booth = r_acc - r_m;
    else if (!r_q[0] && r_qm1)
      w_booth = r_acc + r_m;
  end
  assign w_mul_acc = {w_booth[WIDTH], w_booth[WIDTH:1]};
  assign w_mul_q   = {w_booth[0], r_q[WIDTH-1:1]};

  // Non-restoring step: shift {A,Q} left, then add or subtract M depending on
  // the sign of A before the shift. The top bit lost in the shift is
  // recovered by the modular add/sub since the true remainder fits.
  assign w_div_sh  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_div_acc = r_acc[WIDTH] ? (w_div_sh + r_m) : (w_div_sh - r_m);
  assign w_div_q   = {r_q[WIDTH-2:0], ~w_div_acc[WIDTH]};
  assign w_corr    = r_acc[WIDTH] ? (r_acc + r_m) : r_acc;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!r_sel[1])
          w_state_nxt = S_ADDSUB;
        else if (!r_sel[0])
          w_state_nxt = S_MUL_STEP;
        else if (w_div_zero)
          w_state_nxt = S_DONE;
        else
          w_state_nxt = S_DIV_STEP;
      end
      S_ADDSUB:   w_state_nxt = S_DONE;
      S_MUL_STEP: if (w_last) w_state_nxt = S_DONE;
      S_DIV_STEP: if (w_last) w_state_nxt = S_DIV_CORR;
      S_DIV_CORR: w_state_nxt = S_DONE;
      S_DONE: begin
        w_busy      = 1'b0;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_ovf    <= 1'b0;
`ifdef ALU_FLAGS_EN
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_sel <= bus.sel;
          end
        end
        S_LOAD: begin
          r_acc <= '0;
          r_q   <= r_a;
          // Divisor is unsigned, multiplier operand is signed
          r_m   <= r_sel[0] ? {1'b0, r_b} : {r_b[WIDTH-1], r_b};
          r_qm1 <= 1'b0;
          r_cnt <= '0;
          if (w_div_zero) begin
            r_res_hi <= r_a;
            r_res_lo <= '1;
            r_ovf    <= 1'b1;
`ifdef ALU_FLAGS_EN
            r_zero   <= 1'b0;
            r_neg    <= 1'b0;
`endif
          end
        end
        S_ADDSUB: begin
          r_res_hi <= '0;
          r_res_lo <= w_addsub;
          r_ovf    <= w_addsub_ovf;
`ifdef ALU_FLAGS_EN
          r_zero   <= (w_addsub == '0);
          r_neg    <= w_addsub[WIDTH-1];
`endif
        end
        S_MUL_STEP: begin
          r_acc <= w_mul_acc;
          r_q   <= w_mul_q;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_res_hi <= w_mul_acc[WIDTH-1:0];
            r_res_lo <= w_mul_q;
            r_ovf    <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_zero   <= ({w_mul_acc[WIDTH-1:0], w_mul_q} == '0);
            r_neg    <= w_mul_acc[WIDTH-1];
`endif
          end
        end
        S_DIV_STEP: begin
          r_acc <= w_div_acc;
          r_q   <= w_div_q;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DIV_CORR: begin
          r_acc    <= w_corr;
          r_res_hi <= w_corr[WIDTH-1:0];
          r_res_lo <= r_q;
          r_ovf    <= 1'b0;
`ifdef ALU_FLAGS_EN
          r_zero   <= (r_q == '0);
          r_neg    <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.result_hi = r_res_hi;
  assign bus.result_lo = r_res_lo;
  assign bus.ovf       = r_ovf;
`ifdef ALU_FLAGS_EN
  assign bus.zero      = r_zero;
  assign bus.neg       = r_neg;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu_core
// Purpose  : Self-checking bench for seq_alu_core at WIDTH=8. Directed vector
//            table for all operations plus sequences for ignored start,
//            held start and reset in the middle of a divide.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu_core;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_core_if #(.WIDTH(W)) bus ();

  seq_alu_core #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         ovf;
    int           lat;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Issue one operation from IDLE; lat counts the cycle after the accepting
  // edge as 1. Inputs are scrambled after acceptance to show they are not
  // re-sampled. Returns with the core back in IDLE.
  task automatic run_op(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] hi, output logic [W-1:0] lo,
                        output logic ovf, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sel   = sel;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.sel   = ~sel;
    bus.a     = ~a;
    bus.b     = ~b;
    lat = 1;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.done) lat = -1;
    hi  = bus.result_hi;
    lo  = bus.result_lo;
    ovf = bus.ovf;
    @(posedge clk); #1;
    check("done_single_pulse", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] hi, lo;
    logic         ovf;
    int           lat;
    int           cyc, npulse, first_done, t, t0, t1;

    //          sel    a      b      hi     lo     ovf   lat
    vecs[0]  = '{2'b00, 8'd100, 8'd27,  8'h00, 8'h7F, 1'b0, 3};
    vecs[1]  = '{2'b00, 8'd100, 8'd28,  8'h00, 8'h80, 1'b1, 3};
    vecs[2]  = '{2'b01, 8'd5,   8'd7,   8'h00, 8'hFE, 1'b0, 3};
    vecs[3]  = '{2'b01, 8'h80,  8'h01,  8'h00, 8'h7F, 1'b1, 3};
    vecs[4]  = '{2'b00, 8'hFF,  8'h01,  8'h00, 8'h00, 1'b0, 3};
    vecs[5]  = '{2'b01, 8'h7F,  8'hFF,  8'h00, 8'h80, 1'b1, 3};
    vecs[6]  = '{2'b10, 8'hFD,  8'h05,  8'hFF, 8'hF1, 1'b0, 10};
    vecs[7]  = '{2'b10, 8'h80,  8'h80,  8'h40, 8'h00, 1'b0, 10};
    vecs[8]  = '{2'b10, 8'h00,  8'hFF,  8'h00, 8'h00, 1'b0, 10};
    vecs[9]  = '{2'b10, 8'h7F,  8'h7F,  8'h3F, 8'h01, 1'b0, 10};
    vecs[10] = '{2'b10, 8'h7F,  8'h80,  8'hC0, 8'h80, 1'b0, 10};
    vecs[11] = '{2'b11, 8'd200, 8'd7,   8'd4,  8'd28, 1'b0, 11};
    vecs[12] = '{2'b11, 8'd7,   8'd200, 8'd7,  8'd0,  1'b0, 11};
    vecs[13] = '{2'b11, 8'd255, 8'd1,   8'd0,  8'hFF, 1'b0, 11};
    vecs[14] = '{2'b11, 8'd50,  8'd0,   8'd50, 8'hFF, 1'b1, 2};

    bus.start = 1'b0;
    bus.sel   = '0;
    bus.a     = '0;
    bus.b     = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi",   {24'd0, bus.result_hi}, 32'd0);
    check("rst_lo",   {24'd0, bus.result_lo}, 32'd0);
    check("rst_ovf",  {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].sel, vecs[i].a, vecs[i].b, hi, lo, ovf, lat);
      check($sformatf("v%0d_hi", i),  {24'd0, hi},  {24'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i),  {24'd0, lo},  {24'd0, vecs[i].lo});
      check($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf});
      check($sformatf("v%0d_lat", i), lat, vecs[i].lat);
    end

    // Start pulse during a multiply is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 2'b10; bus.a = 8'hFD; bus.b = 8'h05;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; npulse = 0; first_done = 0;
    hi = '0; lo = '0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done) begin
        npulse++;
        if (first_done == 0) begin
          first_done = cyc;
          hi = bus.result_hi;
          lo = bus.result_lo;
        end
      end
      if (cyc == 5) check("ign_busy", {31'd0, bus.busy}, 32'd1);
      if (cyc == 4) begin
        bus.start = 1'b1; bus.sel = 2'b00; bus.a = 8'd1; bus.b = 8'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("ign_pulses", npulse, 1);
    check("ign_lat", first_done, 10);
    check("ign_result", {16'd0, hi, lo}, 32'h0000FFF1);

    // Start held high: back-to-back adds separated by latency + 1
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 2'b00; bus.a = 8'd1; bus.b = 8'd2;
    t = 0; t0 = -1; t1 = -1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      t++;
      if (bus.done) begin
        if (t0 < 0) t0 = t;
        else if (t1 < 0) t1 = t;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("held_second_pulse", {31'd0, (t1 >= 0)}, 32'd1);
    check("held_spacing", t1 - t0, 4);
    check("held_lo", {24'd0, bus.result_lo}, 32'd3);
    repeat (8) @(posedge clk);

    // Leave non-zero results, then reset in the middle of a divide
    run_op(2'b11, 8'd50, 8'd0, hi, lo, ovf, lat);
    check("pre_rst_hi", {24'd0, hi}, 32'd50);
    @(negedge clk);
    bus.start = 1'b1; bus.sel = 2'b11; bus.a = 8'd200; bus.b = 8'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_hi",   {24'd0, bus.result_hi}, 32'd0);
    check("midrst_lo",   {24'd0, bus.result_lo}, 32'd0);
    check("midrst_ovf",  {31'd0, bus.ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b00, 8'd100, 8'd27, hi, lo, ovf, lat);
    check("post_rst_lo",  {24'd0, lo}, 32'h7F);
    check("post_rst_ovf", {31'd0, ovf}, 32'd0);
    check("post_rst_lat", lat, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_alu_core.md
Name: seq_alu_core

Overview:
- Parametrised sequential ALU: datapath and one-hot controller in one block, successor to the fixed 8-bit control unit.
- Operations: add, subtract, signed Booth radix-2 multiply and unsigned non-restoring divide on WIDTH-bit operands.
- Start/busy/done handshake replaces the bare finish level.
- Sits between the operand registers and the result bus of the ALU subsystem.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH), width of the iteration counter; derived, not overridden.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, operation request; sampled only in IDLE.
- sel, input, 2, operation: 00 add, 01 sub, 10 signed multiply, 11 unsigned divide.
- a, input, WIDTH, operand A (multiplicand / dividend); captured at start.
- b, input, WIDTH, operand B (multiplier / divisor); captured at start.
- busy, output, 1, high from the cycle after acceptance until done.
- done, output, 1, one-cycle pulse; results valid in the same cycle.
- result_hi, output, WIDTH, product high half / remainder / 0 for add-sub.
- result_lo, output, WIDTH, sum / difference / product low half / quotient.
- ovf, output, 1, signed overflow (add/sub) or divide-by-zero (divide); 0 for multiply.

Behaviour:
- Reset (rst_n low, any time, including mid-operation): state IDLE; busy, done, ovf = 0; result_hi, result_lo = 0; internal A/Q/M/counter = 0. Release is synchronous to the next edge.
- States: IDLE, LOAD, ADDSUB, MUL_STEP, DIV_STEP, DIV_CORR, DONE.
- IDLE:
  - start=1: capture a, b and sel; go to LOAD.
  - start=0: remain in IDLE.
- LOAD: A=0, Q=a (multiply/divide), M=b, q_min1=0, counter=0.
  - sel 0x goes to ADDSUB; sel 10 goes to MUL_STEP.
  - sel 11 with b=0 goes to DONE with quotient all ones, remainder=a, ovf=1.
  - sel 11 with b≠0 goes to DIV_STEP.
- ADDSUB: result_lo = a+b or a−b, modulo 2^WIDTH; result_hi=0; ovf = two's-complement overflow; go to DONE.
- MUL_STEP, one iteration per cycle:
  - {Q[0],q_min1}=01: A+=M. {Q[0],q_min1}=10: A−=M. Otherwise no add.
  - Then arithmetic right shift of {A,Q,q_min1}; counter++.
  - Leave after WIDTH iterations: {result_hi,result_lo}={A,Q}, 2WIDTH-bit signed product.
- DIV_STEP, non-restoring, one iteration per cycle:
  - Shift {A,Q} left.
  - A non-negative: A−=M. A negative: A+=M.
  - Q[0] = ~sign(A); counter++.
  - After WIDTH iterations go to DIV_CORR.
  - A is WIDTH+1 bits internally.
- DIV_CORR: if A negative, A+=M. Then result_hi=A[WIDTH-1:0], result_lo=Q.
- DONE: done=1 for exactly one cycle; busy=0; next state IDLE.
- busy=1 in every state except IDLE and DONE.
- Latency from the accepting edge to the done cycle:
  - add/sub: 3 cycles.
  - multiply: WIDTH+2 cycles.
  - divide: WIDTH+3 cycles.
  - divide by zero: 2 cycles.
- start while busy or in DONE is ignored, not queued. start held high re-triggers from IDLE, so back-to-back operations are spaced by one IDLE cycle.
- result_hi, result_lo and ovf hold their values until the next DONE; a, b and sel changing mid-operation have no effect.
- Counter wrap never occurs: the iteration exit is compared at WIDTH−1.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: adds output ports zero (1) and neg (1), updated at DONE and held like the results.
  - zero = 1 when result_lo is 0 (add/sub, divide) or the full 2WIDTH product is 0.
  - neg = MSB of result_lo (add/sub) or result_hi (multiply); 0 for divide.
  - Both reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan (WIDTH=8):
- Add 100+27 → result_lo=0x7F, ovf=0, done 3 cycles after accept. Add 100+28 → result_lo=0x80, ovf=1.
- Sub 5−7 → result_lo=0xFE, result_hi=0x00, ovf=0. Sub 0x80−0x01 → result_lo=0x7F, ovf=1.
- Multiply −3×5 → {hi,lo}=0xFF_F1, done at 10 cycles. −128×−128 → 0x40_00. 0×−1 → 0x00_00.
- Divide 200/7 → lo=28, hi=4, done at 11 cycles. 7/200 → lo=0, hi=7. 50/0 → lo=0xFF, hi=50, ovf=1, done at 2 cycles.
- Pulse start during a multiply → ignored; busy stays 1 and only one done pulse occurs. start held high → consecutive done pulses separated by the operation latency plus 1.
- Deassert rst_n mid-divide → same cycle: busy=0, results=0, state IDLE; a new add after release completes normally.
